// File: rtl/vehicle_sensor_conditioner.sv
// rtl/vehicle_sensor_conditioner.sv - loop-detector synchroniser, debouncer and request latch
// Feeds the side-road VehiclePresent request into TrafficLights_topmodule.
module vehicle_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES    = 1000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SensorRaw,
  input  logic             SideGreen,
  output logic             VehiclePresent,
  output logic [CNT_W-1:0] VehicleCount,
  output logic             Fault
);

  localparam int CTR_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [CTR_W-1:0] DEB_LAST   = CTR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CTR_W-1:0] STUCK_LAST = CTR_W'(STUCK_CYCLES - 1);
  localparam logic [CTR_W-1:0] CTR_ONE    = CTR_W'(1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] QUAL     = 3'd1;
  localparam logic [2:0] OCCUPIED = 3'd2;
  localparam logic [2:0] RELEASE  = 3'd3;
  localparam logic [2:0] FAULT    = 3'd4;

  logic             syncQ1;
  logic             syncQ2;
  logic [2:0]       state;
  logic [2:0]       stateNext;
  logic [CTR_W-1:0] ctr;
  logic [CTR_W-1:0] ctrNext;
  logic             arrival;
  logic             departure;

  // One counter serves debounce, occupancy and fault-recovery timing.
  always_comb begin
    stateNext = state;
    ctrNext   = ctr;
    arrival   = 1'b0;
    departure = 1'b0;
    case (state)
      IDLE: begin
        if (syncQ2) begin
          stateNext = QUAL;
          ctrNext   = CTR_ONE;
        end
      end
      QUAL: begin
        if (!syncQ2) begin
          stateNext = IDLE;
          ctrNext   = '0;
        end else if (ctr == DEB_LAST) begin
          stateNext = OCCUPIED;
          ctrNext   = CTR_ONE;
          arrival   = 1'b1;
        end else begin
          ctrNext = ctr + CTR_ONE;
        end
      end
      OCCUPIED: begin
        if (!syncQ2) begin
          stateNext = RELEASE;
          ctrNext   = CTR_ONE;
        end else if (ctr == STUCK_LAST) begin
          stateNext = FAULT;
          ctrNext   = '0;
        end else begin
          ctrNext = ctr + CTR_ONE;
        end
      end
      RELEASE: begin
        if (syncQ2) begin
          stateNext = OCCUPIED;
          ctrNext   = CTR_ONE;
        end else if (ctr == DEB_LAST) begin
          stateNext = IDLE;
          ctrNext   = '0;
          departure = 1'b1;
        end else begin
          ctrNext = ctr + CTR_ONE;
        end
      end
      FAULT: begin
        // Recovery needs an unbroken run of low samples.
        if (syncQ2) begin
          ctrNext = '0;
        end else if (ctr == DEB_LAST) begin
          stateNext = IDLE;
          ctrNext   = '0;
        end else begin
          ctrNext = ctr + CTR_ONE;
        end
      end
      default: begin
        stateNext = IDLE;
        ctrNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncQ1         <= 1'b0;
      syncQ2         <= 1'b0;
      state          <= IDLE;
      ctr            <= '0;
      VehiclePresent <= 1'b0;
      VehicleCount   <= '0;
      Fault          <= 1'b0;
    end else begin
      syncQ1 <= SensorRaw;
      syncQ2 <= syncQ1;
      state  <= stateNext;
      ctr    <= ctrNext;
      Fault  <= (stateNext == FAULT);
      // Fault forces the request; green beats a same-cycle arrival.
      if (stateNext == FAULT) begin
        VehiclePresent <= 1'b1;
      end else if (state == FAULT || SideGreen) begin
        VehiclePresent <= 1'b0;
      end else if (arrival) begin
        VehiclePresent <= 1'b1;
      end
      if (departure && VehicleCount != {CNT_W{1'b1}}) begin
        VehicleCount <= VehicleCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// tb/tb_vehicle_sensor_conditioner.sv - scoreboard bench for vehicle_sensor_conditioner
module tb_vehicle_sensor_conditioner;

  localparam int DEB   = 4;
  localparam int STUCK = 20;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sensorRaw = 1'b0;
  logic          sideGreen = 1'b0;
  logic          vehiclePresent;
  logic [CW-1:0] vehicleCount;
  logic          fault;

  int edgeCnt = 0;
  int checks  = 0;
  int errors  = 0;
  int s;

  typedef struct {
    int         cyc;
    string      tag;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];

  vehicle_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .STUCK_CYCLES(STUCK),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .SensorRaw(sensorRaw),
    .SideGreen(sideGreen),
    .VehiclePresent(vehiclePresent),
    .VehicleCount(vehicleCount),
    .Fault(fault)
  );

  always #10 clk = ~clk;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic push(input int cyc, input string tag, input logic vp, input logic [1:0] cnt, input logic flt);
    sb.push_back('{cyc: cyc, tag: tag, val: {vp, cnt, flt}});
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got vp/cnt/flt=%b expected %b", tag, got, exp);
    end
  endtask

  // Compare every expectation due after the edge just completed.
  task automatic drain();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edgeCnt) begin
        chk($sformatf("%s@%0d", sb[i].tag, edgeCnt), {vehiclePresent, vehicleCount, fault}, sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) begin
      @(negedge clk);
      drain();
      @(posedge clk);
    end
    #2;
  endtask

  initial begin
    #1 rst = 1'b1;
    #4 chk("reset", {vehiclePresent, vehicleCount, fault}, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    s = edgeCnt; sensorRaw = 1'b1;
    push(s + 5, "arrive_pre", 1'b0, 2'd0, 1'b0);
    push(s + 6, "arrive", 1'b1, 2'd0, 1'b0);
    waitEdges(6);
    sideGreen = 1'b1;
    push(edgeCnt + 1, "green_clear", 1'b0, 2'd0, 1'b0);
    waitEdges(1);
    sideGreen = 1'b0;
    s = edgeCnt; sensorRaw = 1'b0;
    push(s + 5, "depart_pre", 1'b0, 2'd0, 1'b0);
    push(s + 6, "depart", 1'b0, 2'd1, 1'b0);
    waitEdges(7);

    for (int w = 3; w >= 1; w--) begin
      s = edgeCnt; sensorRaw = 1'b1;
      push(s + w + 4, $sformatf("glitch%0d", w), 1'b0, 2'd1, 1'b0);
      waitEdges(w);
      sensorRaw = 1'b0;
      waitEdges(6);
    end

    // Exact arrival latency again proves the glitches left the FSM idle.
    s = edgeCnt; sensorRaw = 1'b1;
    push(s + 5, "rearrive_pre", 1'b0, 2'd1, 1'b0);
    push(s + 6, "rearrive", 1'b1, 2'd1, 1'b0);
    waitEdges(6);
    s = edgeCnt; sensorRaw = 1'b0;
    push(s + 6, "depart2_hold", 1'b1, 2'd2, 1'b0);
    waitEdges(7);

    push(edgeCnt + 1, "green_clear2", 1'b0, 2'd2, 1'b0);
    sideGreen = 1'b1;
    waitEdges(1);
    s = edgeCnt; sensorRaw = 1'b1;
    push(s + 6, "green_arrive", 1'b0, 2'd2, 1'b0);
    waitEdges(8);
    sideGreen = 1'b0;
    push(edgeCnt + 1, "post_green", 1'b0, 2'd2, 1'b0);
    push(edgeCnt + 3, "post_green3", 1'b0, 2'd2, 1'b0);
    waitEdges(3);
    s = edgeCnt; sensorRaw = 1'b0;
    push(s + 6, "depart3", 1'b0, 2'd3, 1'b0);
    waitEdges(7);

    s = edgeCnt; sensorRaw = 1'b1;
    push(s + 6, "stuck_arrive", 1'b1, 2'd3, 1'b0);
    push(s + 24, "stuck_pre", 1'b1, 2'd3, 1'b0);
    push(s + 25, "stuck_fault", 1'b1, 2'd3, 1'b1);
    waitEdges(25);
    sideGreen = 1'b1;
    push(edgeCnt + 2, "fault_green", 1'b1, 2'd3, 1'b1);
    waitEdges(2);
    s = edgeCnt; sensorRaw = 1'b0; sideGreen = 1'b0;
    push(s + 5, "fault_hold", 1'b1, 2'd3, 1'b1);
    push(s + 6, "fault_clear", 1'b0, 2'd3, 1'b0);
    waitEdges(7);

    for (int v = 0; v < 2; v++) begin
      s = edgeCnt; sensorRaw = 1'b1;
      push(s + 6, $sformatf("sat_arrive%0d", v), 1'b1, 2'd3, 1'b0);
      waitEdges(8);
      s = edgeCnt; sensorRaw = 1'b0;
      push(s + 6, $sformatf("sat_depart%0d", v), 1'b1, 2'd3, 1'b0);
      waitEdges(7);
    end

    s = edgeCnt; sensorRaw = 1'b1;
    waitEdges(3);
    #3 chk("pre_rst", {vehiclePresent, vehicleCount, fault}, 4'b1110);
    rst = 1'b1;
    #1 chk("async_rst", {vehiclePresent, vehicleCount, fault}, 4'b0000);
    #2 rst = 1'b0;
    push(s + 4, "post_rst_idle", 1'b0, 2'd0, 1'b0);
    push(s + 8, "post_rst_pre", 1'b0, 2'd0, 1'b0);
    push(s + 9, "post_rst_arrive", 1'b1, 2'd0, 1'b0);
    waitEdges(10);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vehicle_sensor_conditioner.md
# vehicle_sensor_conditioner

Conditions the raw side-road loop-detector signal into the clean, latched `VehiclePresent` request consumed by `TrafficLights_topmodule`. It sits directly upstream of the traffic-light controller. Its functions:
- synchronise and debounce the asynchronous sensor;
- hold the request until the controller serves the side road;
- count departed vehicles;
- flag a stuck-high sensor, forcing a fail-safe request.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples needed to accept an edge (legal range 2..255).
- `STUCK_CYCLES`, default 1000: continuous cycles in OCCUPIED before a sensor fault is declared (must be greater than `DEBOUNCE_CYCLES`).
- `CNT_W`, default 8: width of `VehicleCount`.

Ports:
- `clk`, input, 1: system clock (50 MHz in the top level).
- `rst`, input, 1: asynchronous, active-high reset.
- `SensorRaw`, input, 1: raw loop detector output; asynchronous and may bounce.
- `SideGreen`, input, 1: high while the controller shows side-road green (derived from `SideLights`).
- `VehiclePresent`, output, 1: latched side-road service request to the controller.
- `VehicleCount`, output, `CNT_W`: number of qualified departures; saturates at all-ones.
- `Fault`, output, 1: sensor stuck-high indication.

## Operation
- **Synchroniser:** two-flop synchroniser on `SensorRaw` produces `s2`. All FSM decisions use `s2` only.
- **Shared counter:** one debounce/occupancy counter, wide enough for `STUCK_CYCLES`.
- **FSM states:** IDLE, QUAL, OCCUPIED, RELEASE, FAULT.
- **IDLE:**
  - `s2`=1 → QUAL, counter=1.
- **QUAL:**
  - `s2`=0 → IDLE, counter cleared. Glitches are fully rejected.
  - `s2`=1 and counter=`DEBOUNCE_CYCLES`-1 → OCCUPIED. This edge is the "arrival event". Counter=1.
  - Otherwise counter+1.
- **OCCUPIED:**
  - `s2`=0 → RELEASE, counter=1.
  - `s2`=1 and counter=`STUCK_CYCLES`-1 → FAULT.
  - Otherwise counter+1.
- **RELEASE:**
  - `s2`=1 → OCCUPIED, counter=1. The occupancy count restarts; this is not a new arrival.
  - `s2`=0 and counter=`DEBOUNCE_CYCLES`-1 → IDLE. This edge is the "departure event": `VehicleCount`+1, saturating.
  - Otherwise counter+1.
- **FAULT:**
  - `Fault`=1 and `VehiclePresent` forced 1, regardless of `SideGreen`.
  - `s2`=0 for `DEBOUNCE_CYCLES` consecutive cycles → IDLE, `Fault`=0, request latch cleared. No count increment.
  - Any `s2`=1 in FAULT restarts that count.
- **Request latch (all states except FAULT)**, evaluated each edge in priority order:
  1. `SideGreen`=1 → latch cleared.
  2. Arrival event → latch set.
  3. Otherwise the latch holds.
- **Simultaneous events:**
  - Arrival with `SideGreen`=1 leaves the latch 0; the vehicle is served by the current green.
  - A vehicle still occupying the sensor when green ends does not re-request. Only a new arrival sets the latch.
- **`VehicleCount`** never wraps.

## Timing
- **Reset:** asynchronous assertion → state IDLE, counter 0, synchroniser flops 0, `VehiclePresent`=0, `VehicleCount`=0, `Fault`=0. Release is synchronous to `clk`.
- **Reset mid-operation:** reset in any state discards the pending request, the fault and the count immediately. No glitching outputs after deassertion.
- **Arrival latency:** with `SensorRaw` stable high from sampling edge 1, `VehiclePresent` is high after edge `DEBOUNCE_CYCLES`+2. That is edge 6 for the default (120 ns at 50 MHz).
- **Departure latency:** `VehicleCount` updates after edge `DEBOUNCE_CYCLES`+2, counting from the first edge sampling `SensorRaw` low.
- **Fault latency:** `Fault` rises on the edge where OCCUPIED has completed `STUCK_CYCLES` consecutive `s2`=1 cycles.
- **Request clear:** `SideGreen` clears `VehiclePresent` on the first edge sampling it high. `SideGreen` is synchronous to `clk`; it is not re-synchronised.
- **Registered outputs:** all outputs are registered. No combinational path from inputs to outputs.

## Test plan
- **Clean arrival:** reset 20 ns, then `SensorRaw`=1 held; `DEBOUNCE_CYCLES`=4, 20 ns clock → `VehiclePresent` rises exactly 6 edges after the first sampling edge. `VehicleCount`=0, `Fault`=0.
- **Glitch rejection:** `SensorRaw` pulses high for 3 cycles, 2 cycles, then 1 cycle → `VehiclePresent` stays 0 and the FSM returns to IDLE each time.
- **Service handshake:** latch set, then `SideGreen`=1 for one cycle → `VehiclePresent`=0 on the next edge. Sensor drop of ≥4 cycles → `VehicleCount`=1.
- **Arrival during green:** `SideGreen`=1 held while a vehicle qualifies → `VehiclePresent` stays 0. After green ends with the vehicle still present → stays 0.
- **Stuck sensor:** `STUCK_CYCLES`=20, `SensorRaw` held high → `Fault`=1 and `VehiclePresent`=1 even with `SideGreen`=1. Then `SensorRaw` low for 4+2 cycles → `Fault`=0, `VehiclePresent`=0, count unchanged.
- **Saturation and reset:** `CNT_W`=2 with 5 vehicles → `VehicleCount`=3. Assert `rst` asynchronously mid-QUAL → all outputs 0 immediately, before the next clock edge.
